// File: rtl/seq_divider.sv
// Restoring radix-2 sequential divider with independent valid/ready operand channels.
// Optional macro DIV_ZERO_EARLY_EN: a zero divisor bypasses the iteration loop.
module seq_divider #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     divisor_data,
    input  logic                 divisor_valid,
    output logic                 divisor_ready,
    input  logic [WIDTH-1:0]     dividend_data,
    input  logic                 dividend_valid,
    output logic                 dividend_ready,
    output logic                 dout_valid,
    output logic [2*WIDTH-1:0]   dout_data
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_dvd_held;
    logic               r_dvs_held;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_dout;

    logic               w_start;
    logic               w_early;
    logic               w_dvs_zero;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH-1:0]   w_dvs_abs;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_start    = (r_state == IDLE) && r_dvd_held && r_dvs_held;
    assign w_dvs_zero = (r_dvs == '0);
    assign w_dvd_neg  = SIGNED && r_dvd[WIDTH-1];
    assign w_dvs_neg  = SIGNED && r_dvs[WIDTH-1];
    assign w_dvd_abs  = w_dvd_neg ? -r_dvd : r_dvd;
    assign w_dvs_abs  = w_dvs_neg ? -r_dvs : r_dvs;
    assign w_trial    = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
    assign w_quo_fix  = r_sign_q ? -r_quo : r_quo;
    assign w_rem_fix  = r_sign_r ? -r_rem : r_rem;

    // Early exit still passes through FIX so the sign fix-up stays in one place.
`ifdef DIV_ZERO_EARLY_EN
    assign w_early = w_dvs_zero;
`else
    assign w_early = 1'b0;
`endif

    assign divisor_ready  = ~r_dvs_held & (r_state == IDLE);
    assign dividend_ready = ~r_dvd_held & (r_state == IDLE);
    assign dout_valid     = (r_state == DONE);
    assign dout_data      = r_dout;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = w_early ? FIX : CALC;
            CALC:    if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd_held <= 1'b0;
            r_dvs_held <= 1'b0;
            r_cnt      <= '0;
            r_dout     <= '0;
        end else begin
            if (divisor_valid && divisor_ready)   r_dvs_held <= 1'b1;
            if (dividend_valid && dividend_ready) r_dvd_held <= 1'b1;
            if (r_state == DONE) begin
                r_dvd_held <= 1'b0;
                r_dvs_held <= 1'b0;
            end
            if (w_start)               r_cnt <= CW'(WIDTH - 1);
            else if (r_state == CALC)  r_cnt <= r_cnt - CW'(1);
            if (r_state == FIX)        r_dout <= {w_quo_fix, w_rem_fix};
        end
    end

    // NOTE: datapath registers have no reset; each is loaded before use and the held flags and state gate every read.
    always_ff @(posedge clk) begin
        if (divisor_valid && divisor_ready)   r_dvs <= divisor_data;
        if (dividend_valid && dividend_ready) r_dvd <= dividend_data;
        if (w_start) begin
            r_div    <= w_dvs_abs;
            // A zero divisor keeps the all-ones quotient regardless of operand signs.
            r_sign_q <= (w_dvd_neg ^ w_dvs_neg) & ~w_dvs_zero;
            r_sign_r <= w_dvd_neg;
            if (w_early) begin
                r_rem <= w_dvd_abs;
                r_quo <= '1;
            end else begin
                r_rem <= '0;
                r_quo <= w_dvd_abs;
            end
        end else if (r_state == CALC) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: a signed and an unsigned seq_divider share one stimulus stream.
// Directed vectors, reset abort, back-to-back and random operands against an arithmetic model.
module tb_seq_divider;
    localparam int W = 32;
`ifdef DIV_ZERO_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  dvs_data;
    logic [W-1:0]  dvd_data;
    logic          dvs_valid;
    logic          dvd_valid;
    logic          s_dvs_rdy, s_dvd_rdy, s_vld;
    logic          u_dvs_rdy, u_dvd_rdy, u_vld;
    logic [2*W-1:0] s_dout, u_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W), .SIGNED(1'b1)) u_sdiv (
        .clk(clk), .reset(reset),
        .divisor_data(dvs_data), .divisor_valid(dvs_valid), .divisor_ready(s_dvs_rdy),
        .dividend_data(dvd_data), .dividend_valid(dvd_valid), .dividend_ready(s_dvd_rdy),
        .dout_valid(s_vld), .dout_data(s_dout)
    );

    seq_divider #(.WIDTH(W), .SIGNED(1'b0)) u_udiv (
        .clk(clk), .reset(reset),
        .divisor_data(dvs_data), .divisor_valid(dvs_valid), .divisor_ready(u_dvs_rdy),
        .dividend_data(dvd_data), .dividend_valid(dvd_valid), .dividend_ready(u_dvd_rdy),
        .dout_valid(u_vld), .dout_data(u_dout)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          skew;
        logic [63:0] exp_s;
        logic [63:0] exp_u;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int          sa, sb;
        logic [31:0] q, r;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    function automatic int exp_latency(input logic [31:0] b);
        return (EARLY && b == 32'h0) ? 2 : W + 2;
    endfunction

    // Latency counts clock edges after the edge that captured the second operand.
    task automatic wait_result(input int exp_lat, input logic [63:0] exp_s, input logic [63:0] exp_u,
                               input string tag);
        int lat;
        bit busy_ok;
        bit seen;
        lat = 0; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (s_vld || u_vld) seen = 1'b1;
            if (s_dvs_rdy || s_dvd_rdy || u_dvs_rdy || u_dvd_rdy) busy_ok = 1'b0;
        end
        check($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("%s s_valid", tag), 64'(s_vld), 64'd1);
        check($sformatf("%s u_valid", tag), 64'(u_vld), 64'd1);
        check($sformatf("%s s_data", tag), s_dout, exp_s);
        check($sformatf("%s u_data", tag), u_dout, exp_u);
        check($sformatf("%s busy_readies_low", tag), 64'(busy_ok), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s valid_one_cycle", tag), {62'd0, s_vld, u_vld}, 64'd0);
        check($sformatf("%s s_data_hold", tag), s_dout, exp_s);
        check($sformatf("%s readies_back", tag), {60'd0, s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}, 64'hF);
    endtask

    // skew > 0: dividend leads by skew cycles; skew < 0: divisor leads. The early
    // channel keeps offering a different value while it is held.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int skew,
                          input logic [63:0] exp_s, input logic [63:0] exp_u, input string tag);
        int k;
        bit rdy_ok;
        k = (skew < 0) ? -skew : skew;
        rdy_ok = 1'b1;
        @(negedge clk);
        if (skew >= 0) begin dvd_data = a; dvd_valid = 1'b1; end
        if (skew <= 0) begin dvs_data = b; dvs_valid = 1'b1; end
        @(posedge clk);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            if (skew > 0) begin
                dvd_data = ~a;
                if (s_dvd_rdy || u_dvd_rdy || !s_dvs_rdy || !u_dvs_rdy) rdy_ok = 1'b0;
                if (i == k) begin dvs_data = b; dvs_valid = 1'b1; end
            end else begin
                dvs_data = ~b;
                if (s_dvs_rdy || u_dvs_rdy || !s_dvd_rdy || !u_dvd_rdy) rdy_ok = 1'b0;
                if (i == k) begin dvd_data = a; dvd_valid = 1'b1; end
            end
            @(posedge clk);
        end
        if (k > 0) check($sformatf("%s one_held_readies", tag), 64'(rdy_ok), 64'd1);
        @(negedge clk);
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        dvd_data  = '0;
        dvs_data  = '0;
        wait_result(exp_latency(b), exp_s, exp_u, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, cyc, t1, t2, rdy_cyc;
        bit pending, sent;
        logic [31:0] ra, rb;
        int rskew;

        vecs[0]  = '{32'd100,        32'd7,          0, {32'd14, 32'd2},                   {32'd14, 32'd2}};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          3, {32'hFFFF_FFFD, 32'hFFFF_FFFF},    {32'h7FFF_FFFC, 32'd1}};
        vecs[2]  = '{32'h8000_0000,  32'hFFFF_FFFF,  0, {32'h8000_0000, 32'h0},            {32'h0, 32'h8000_0000}};
        vecs[3]  = '{32'd5,          32'd0,          0, {32'hFFFF_FFFF, 32'd5},            {32'hFFFF_FFFF, 32'd5}};
        vecs[4]  = '{32'hFFFF_FFFB,  32'd0,         -2, {32'hFFFF_FFFF, 32'hFFFF_FFFB},    {32'hFFFF_FFFF, 32'hFFFF_FFFB}};
        vecs[5]  = '{32'd7,          32'hFFFF_FFFE, -1, {32'hFFFF_FFFD, 32'd1},            {32'd0, 32'd7}};
        vecs[6]  = '{32'd0,          32'd5,          0, {32'd0, 32'd0},                    {32'd0, 32'd0}};
        vecs[7]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, {32'd1, 32'd0},                    {32'd1, 32'd0}};
        vecs[8]  = '{32'd9,          32'd3,          0, {32'd3, 32'd0},                    {32'd3, 32'd0}};
        vecs[9]  = '{32'h8000_0000,  32'd1,          0, {32'h8000_0000, 32'h0},            {32'h8000_0000, 32'h0}};
        vecs[10] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  0, {32'd14, 32'hFFFF_FFFE},           {32'd0, 32'hFFFF_FF9C}};

        reset = 1'b1; dvs_valid = 1'b0; dvd_valid = 1'b0; dvs_data = '0; dvd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset readies", {60'd0, s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}, 64'hF);
        check("reset valid", {62'd0, s_vld, u_vld}, 64'd0);
        check("reset s_data", s_dout, 64'd0);
        check("reset u_data", u_dout, 64'd0);
        reset = 1'b0;

        foreach (vecs[i])
            do_div(vecs[i].a, vecs[i].b, vecs[i].skew, vecs[i].exp_s, vecs[i].exp_u,
                   $sformatf("vec%0d", i));

        // Abort a divide in its tenth CALC cycle.
        @(negedge clk);
        dvd_data = 32'd1000; dvs_data = 32'd3; dvd_valid = 1'b1; dvs_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset readies", {60'd0, s_dvs_rdy, s_dvd_rdy, u_dvs_rdy, u_dvd_rdy}, 64'hF);
        check("midreset valid", {62'd0, s_vld, u_vld}, 64'd0);
        check("midreset s_data", s_dout, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (s_vld || u_vld) pulses++;
        end
        check("midreset no_result", 64'(pulses), 64'd0);
        do_div(32'd9, 32'd3, 0, {32'd3, 32'd0}, {32'd3, 32'd0}, "after_reset");

        // Back-to-back: the second pair stays valid through the whole first divide.
        @(negedge clk);
        dvd_data = 32'd100; dvs_data = 32'd7; dvd_valid = 1'b1; dvs_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dvd_data = 32'd200; dvs_data = 32'd9;
        cyc = 0; t1 = -1; t2 = -1; rdy_cyc = -1; pending = 1'b0; sent = 1'b0;
        while (cyc < 150 && t2 < 0) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (pending) begin
                dvd_valid = 1'b0; dvs_valid = 1'b0; pending = 1'b0;
            end
            if (s_vld) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    check("b2b first data", s_dout, {32'd14, 32'd2});
                end else begin
                    t2 = cyc;
                    check("b2b second s_data", s_dout, {32'd22, 32'd2});
                    check("b2b second u_data", u_dout, {32'd22, 32'd2});
                end
            end
            if (!sent && t1 >= 0 && s_dvd_rdy && s_dvs_rdy) begin
                sent = 1'b1; pending = 1'b1; rdy_cyc = cyc;
            end
        end
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        check("b2b first latency", 64'(t1), 64'(W + 2));
        check("b2b recapture cycle", 64'(rdy_cyc), 64'(t1 + 1));
        check("b2b spacing", 64'(t2 - t1), 64'(W + 4));
        repeat (2) @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       begin ra = $urandom; rb = 32'h0; end
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
                3:       begin ra = $urandom; rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1; end
                4:       begin ra = -$urandom_range(0, 1000); rb = -$urandom_range(1, 50); end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            rskew = int'($urandom_range(0, 6)) - 3;
            do_div(ra, rb, rskew, ref_div(ra, rb, 1'b1), ref_div(ra, rb, 1'b0),
                   $sformatf("rand%0d %h/%h", n, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
